// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : multicycle_ctrl
//  Purpose : Moore control FSM for a multicycle MIPS-subset datapath sharing
//            one memory for fetch and data; counts retired instructions.
//  Rev     : 1.0  initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             pc_write_cond_o,
  output logic             pc_source_o,
  output logic             ir_write_o,
  output logic             i_or_d_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             reg_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic [3:0]       state_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_FUNC = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXR    = 4'd3,
    ST_WBR    = 4'd4,
    ST_EXI    = 4'd5,
    ST_WBI    = 4'd6,
    ST_BEQ    = 4'd7,
    ST_MADDR  = 4'd8,
    ST_MRD    = 4'd9,
    ST_MWB    = 4'd10,
    ST_MWR    = 4'd11,
    ST_TRAP   = 4'd12
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; retire marks the final cycle of each completed instruction.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      ST_RST:    state_d = ST_FETCH;
      ST_FETCH:  if (mem_ready_i) state_d = ST_DECODE;
      ST_DECODE: begin
        case (instr_op_i)
          OP_RTYPE:         state_d = ST_EXR;
          OP_ADDI, OP_SLTI: state_d = ST_EXI;
          OP_BEQ:           state_d = ST_BEQ;
          OP_LW, OP_SW:     state_d = ST_MADDR;
          default:          state_d = ST_TRAP;
        endcase
      end
      ST_EXR:    state_d = ST_WBR;
      ST_WBR: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_EXI:    state_d = ST_WBI;
      ST_WBI: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_BEQ: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_MADDR:  state_d = (instr_op_i == OP_LW) ? ST_MRD : ST_MWR;
      ST_MRD:    if (mem_ready_i) state_d = ST_MWB;
      ST_MWB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_MWR: begin
        if (mem_ready_i) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end
      end
      ST_TRAP:   state_d = ST_TRAP;
      default:   state_d = ST_TRAP;
    endcase
  end

  assign cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

  // Moore outputs per state; only FETCH qualifies its writes with mem_ready_i.
  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_source_o     = 1'b0;
    ir_write_o      = 1'b0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    reg_write_o     = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = SRCB_RT;
    alu_op_o        = ALU_ADD;
    illegal_o       = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      ST_DECODE: alu_src_b_o = SRCB_BR;
      ST_EXR: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FUNC;
      end
      ST_WBR: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      ST_EXI: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = (instr_op_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      ST_WBI:    reg_write_o = 1'b1;
      ST_BEQ: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = ALU_SUB;
        pc_write_cond_o = 1'b1;
        pc_source_o     = 1'b1;
      end
      ST_MADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
      end
      ST_MRD: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
      end
      ST_MWB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      ST_MWR: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
      end
      ST_TRAP:   illegal_o = 1'b1;
      default:   ;
    endcase
  end

  assign state_o     = state_q;
  assign instr_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_multicycle_ctrl
//  Purpose : Randomized instruction-stream bench for multicycle_ctrl (CNT_W=4).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] instr_op_i;
  logic       mem_ready_i;
  logic       pc_write_o, pc_write_cond_o, pc_source_o, ir_write_o, i_or_d_o;
  logic       mem_read_o, mem_write_o, reg_write_o, reg_dst_o, mem_to_reg_o;
  logic       alu_src_a_o, illegal_o;
  logic [1:0] alu_src_b_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;
  logic [3:0] instr_cnt_o;
  logic [16:0] obs;

  int n_pass  = 0;
  int n_total = 0;
  int cnt_m   = 0;

  multicycle_ctrl #(.CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .pc_source_o(pc_source_o),
    .ir_write_o(ir_write_o), .i_or_d_o(i_or_d_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .alu_op_o(alu_op_o), .state_o(state_o), .illegal_o(illegal_o), .instr_cnt_o(instr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  assign obs = {pc_write_o, pc_write_cond_o, pc_source_o, ir_write_o, i_or_d_o,
                mem_read_o, mem_write_o, reg_write_o, reg_dst_o, mem_to_reg_o,
                alu_src_a_o, alu_src_b_o, alu_op_o, illegal_o};

  // Output table: what each phase of an instruction must drive.
  function automatic logic [16:0] exp_out(input logic [3:0] s, input logic r, input logic [5:0] o);
    logic pcw, pcwc, pcs, irw, iod, mr, mw, rw, rd, m2r, sa, il;
    logic [1:0] sb;
    logic [2:0] ao;
    {pcw, pcwc, pcs, irw, iod, mr, mw, rw, rd, m2r, sa, il} = '0;
    sb = 2'b00;
    ao = 3'b000;
    case (s)
      4'd1:  begin mr = 1; sb = 2'b01; pcw = r; irw = r; end
      4'd2:  sb = 2'b11;
      4'd3:  begin sa = 1; ao = 3'b010; end
      4'd4:  begin rw = 1; rd = 1; end
      4'd5:  begin sa = 1; sb = 2'b10; ao = (o == 6'h0A) ? 3'b011 : 3'b000; end
      4'd6:  rw = 1;
      4'd7:  begin sa = 1; ao = 3'b001; pcwc = 1; pcs = 1; end
      4'd8:  begin sa = 1; sb = 2'b10; end
      4'd9:  begin mr = 1; iod = 1; end
      4'd10: begin rw = 1; m2r = 1; end
      4'd11: begin mw = 1; iod = 1; end
      4'd12: il = 1;
      default: ;
    endcase
    return {pcw, pcwc, pcs, irw, iod, mr, mw, rw, rd, m2r, sa, sb, ao, il};
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom);
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom);
  endfunction

  function automatic bit is_legal(input logic [5:0] o);
    return (o == 6'h00) || (o == 6'h08) || (o == 6'h0A) || (o == 6'h04) ||
           (o == 6'h23) || (o == 6'h2B);
  endfunction

  task automatic chk(input string tag, input logic [3:0] es, input logic [16:0] ev, input int ec);
    n_total++;
    assert (state_o === es) n_pass++;
    else $error("FAIL %s state: got %0d expected %0d", tag, state_o, es);
    n_total++;
    assert (obs === ev) n_pass++;
    else $error("FAIL %s outputs(state %0d): got %05h expected %05h", tag, es, obs, ev);
    n_total++;
    assert (instr_cnt_o === 4'(ec)) n_pass++;
    else $error("FAIL %s instr_cnt: got %0d expected %0d", tag, instr_cnt_o, 4'(ec));
  endtask

  task automatic step(input logic rdy, input logic [5:0] op, input logic [3:0] st, input string tag);
    @(negedge clk_i);
    mem_ready_i = rdy;
    instr_op_i  = op;
    #1;
    chk(tag, st, exp_out(st, rdy, op), cnt_m);
  endtask

  task automatic retire();
    cnt_m = (cnt_m + 1) % 16;
  endtask

  // One instruction expanded into its phases; fw/mw are memory wait cycles.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input string tag);
    for (int i = 0; i < fw; i++) step(1'b0, rnd_op(), 4'd1, tag);
    step(1'b1, rnd_op(), 4'd1, tag);
    step(rnd_bit(), op, 4'd2, tag);
    case (op)
      6'h00: begin
        step(rnd_bit(), rnd_op(), 4'd3, tag);
        step(rnd_bit(), rnd_op(), 4'd4, tag);
        retire();
      end
      6'h08, 6'h0A: begin
        step(rnd_bit(), op, 4'd5, tag);
        step(rnd_bit(), rnd_op(), 4'd6, tag);
        retire();
      end
      6'h04: begin
        step(rnd_bit(), rnd_op(), 4'd7, tag);
        retire();
      end
      6'h23: begin
        step(rnd_bit(), op, 4'd8, tag);
        for (int i = 0; i < mw; i++) step(1'b0, rnd_op(), 4'd9, tag);
        step(1'b1, rnd_op(), 4'd9, tag);
        step(rnd_bit(), rnd_op(), 4'd10, tag);
        retire();
      end
      6'h2B: begin
        step(rnd_bit(), op, 4'd8, tag);
        for (int i = 0; i < mw; i++) step(1'b0, rnd_op(), 4'd11, tag);
        step(1'b1, rnd_op(), 4'd11, tag);
        retire();
      end
      default: step(rnd_bit(), rnd_op(), 4'd12, tag);
    endcase
  endtask

  task automatic assert_reset(input string tag);
    rst_i = 1'b0;
    cnt_m = 0;
    #1;
    chk(tag, 4'd0, 17'd0, 0);
  endtask

  task automatic release_reset(input string tag);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk(tag, 4'd0, 17'd0, 0);
  endtask

  initial begin
    logic [5:0] legal [6];
    logic [5:0] bad;
    legal = '{6'h00, 6'h08, 6'h0A, 6'h04, 6'h23, 6'h2B};
    mem_ready_i = 1'b1;
    instr_op_i  = 6'h00;

    assert_reset("reset");
    repeat (2) @(negedge clk_i);
    #1;
    chk("reset_hold", 4'd0, 17'd0, 0);
    release_reset("reset_release");

    run_instr(6'h00, 0, 0, "rtype");
    run_instr(6'h23, 1, 3, "lw_wait");
    run_instr(6'h2B, 0, 0, "sw");
    run_instr(6'h04, 0, 0, "beq");
    run_instr(6'h08, 0, 0, "addi");
    run_instr(6'h0A, 2, 0, "slti");
    run_instr(6'h2B, 0, 2, "sw_wait");

    for (int k = 0; k < 60; k++)
      run_instr(legal[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 3), "random");

    while (cnt_m != 15) run_instr(6'h00, 0, 0, "fill");
    run_instr(6'h04, 0, 0, "wrap");
    run_instr(6'h00, 0, 0, "after_wrap");

    @(negedge clk_i);
    mem_ready_i = 1'b0;
    instr_op_i  = rnd_op();
    #1;
    chk("fetch_wait", 4'd1, exp_out(4'd1, 1'b0, instr_op_i), cnt_m);
    assert_reset("async_rst_fetch");
    release_reset("release_fetch");

    run_instr(6'h00, 0, 0, "pre_trap");
    run_instr(6'h08, 0, 0, "pre_trap");
    run_instr(6'h3F, 0, 0, "trap");
    for (int i = 0; i < 19; i++) step(rnd_bit(), rnd_op(), 4'd12, "trap_hold");
    assert_reset("trap_clear");
    release_reset("trap_release");

    bad = rnd_op();
    while (is_legal(bad)) bad = rnd_op();
    run_instr(6'h23, 0, 1, "pre_trap2");
    run_instr(bad, 1, 0, "trap_rand");
    for (int i = 0; i < 3; i++) step(rnd_bit(), rnd_op(), 4'd12, "trap_hold2");
    assert_reset("trap_clear2");
    release_reset("trap_release2");
    run_instr(6'h0A, 0, 0, "post_trap");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
